universal_shift_reg: RTL and testbench



---
 rtl/universal_shift_reg.sv | 72 +++++++
 tb/tb_universal_shift_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register with true/complement outputs
// Edge-triggered storage (master-slave behaviour) supporting hold, load, shift, rotate, clear and set.
module universal_shift_reg #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_N,
  output logic             sout_l,
  output logic             sout_r
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_SET  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_sout_l;
  logic             r_sout_r;
  logic [WIDTH-1:0] w_next;
  logic             w_shift_l;
  logic             w_shift_r;

  always_comb begin
    w_next = r_q;
    case (mode)
      MODE_HOLD: w_next = r_q;
      MODE_LOAD: w_next = d;
      MODE_SHL:  w_next = {r_q[WIDTH-2:0], sin_l};
      MODE_SHR:  w_next = {sin_r, r_q[WIDTH-1:1]};
      MODE_ROL:  w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ROR:  w_next = {r_q[0], r_q[WIDTH-1:1]};
      MODE_CLR:  w_next = '0;
      MODE_SET:  w_next = '1;
      // An unknown mode poisons the register so misuse is visible in simulation
      default:   w_next = 'x;
    endcase
  end

  assign w_shift_l = (mode == MODE_SHL) || (mode == MODE_ROL);
  assign w_shift_r = (mode == MODE_SHR) || (mode == MODE_ROR);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_q      <= RESET_VAL;
      r_sout_l <= 1'b0;
      r_sout_r <= 1'b0;
    end else begin
      r_q <= w_next;
      if (w_shift_l) r_sout_l <= r_q[WIDTH-1];
      if (w_shift_r) r_sout_r <= r_q[0];
    end
  end

  // Complement is derived, never stored, so it can never disagree with q
  assign q      = r_q;
  assign q_N    = ~r_q;
  assign sout_l = r_sout_l;
  assign sout_r = r_sout_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg at WIDTH 8, 2 and 16
// Arithmetic reference model checked every falling edge, plus directed literal expectations.
module tb_universal_shift_reg;

  logic clk;
  logic rst_n;

  logic [2:0]  m8,  m2,  m16;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [15:0] d16;
  logic        sl8, sr8, sl2, sr2, sl16, sr16;

  logic [7:0]  q8,  qn8;
  logic [1:0]  q2,  qn2;
  logic [15:0] q16, qn16;
  logic        ol8, or8, ol2, or2, ol16, or16;

  int n_checks = 0;
  int n_pass   = 0;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clock(clk), .reset_N(rst_n), .mode(m8), .d(d8), .sin_l(sl8), .sin_r(sr8),
    .q(q8), .q_N(qn8), .sout_l(ol8), .sout_r(or8));

  universal_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
    .clock(clk), .reset_N(rst_n), .mode(m2), .d(d2), .sin_l(sl2), .sin_r(sr2),
    .q(q2), .q_N(qn2), .sout_l(ol2), .sout_r(or2));

  universal_shift_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) dut16 (
    .clock(clk), .reset_N(rst_n), .mode(m16), .d(d16), .sin_l(sl16), .sin_r(sr16),
    .q(q16), .q_N(qn16), .sout_l(ol16), .sout_r(or16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mask_of(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Next register value from plain arithmetic on the old value
  function automatic logic [31:0] model_next(input logic [31:0] q, input logic [2:0] m,
                                             input logic [31:0] d, input logic sl,
                                             input logic sr, input int w);
    logic [31:0] mk;
    logic [31:0] top;
    mk  = mask_of(w);
    top = 32'd1 << (w - 1);
    case (m)
      3'd0:    return q;
      3'd1:    return d & mk;
      3'd2:    return ((q * 2) + (sl ? 32'd1 : 32'd0)) & mk;
      3'd3:    return (q / 2) + (sr ? top : 32'd0);
      3'd4:    return ((q * 2) & mk) + (q / top);
      3'd5:    return (q / 2) + ((q % 2) * top);
      3'd6:    return 32'd0;
      default: return mk;
    endcase
  endfunction

  logic [31:0] mq8, mq2, mq16;
  logic        ml8, mr8, ml2, mr2, ml16, mr16;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq8 <= 32'hA5; ml8 <= 1'b0; mr8 <= 1'b0;
      mq2 <= 32'h0;  ml2 <= 1'b0; mr2 <= 1'b0;
      mq16 <= 32'h0; ml16 <= 1'b0; mr16 <= 1'b0;
    end else begin
      mq8  <= model_next(mq8, m8, {24'd0, d8}, sl8, sr8, 8);
      mq2  <= model_next(mq2, m2, {30'd0, d2}, sl2, sr2, 2);
      mq16 <= model_next(mq16, m16, {16'd0, d16}, sl16, sr16, 16);
      if (m8 == 3'd2 || m8 == 3'd4)   ml8  <= (mq8 >= 32'd128);
      if (m8 == 3'd3 || m8 == 3'd5)   mr8  <= (mq8 % 2) == 1;
      if (m2 == 3'd2 || m2 == 3'd4)   ml2  <= (mq2 >= 32'd2);
      if (m2 == 3'd3 || m2 == 3'd5)   mr2  <= (mq2 % 2) == 1;
      if (m16 == 3'd2 || m16 == 3'd4) ml16 <= (mq16 >= 32'd32768);
      if (m16 == 3'd3 || m16 == 3'd5) mr16 <= (mq16 % 2) == 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("q8",      32'(q8),   mq8);
    chk("q8_N",    32'(qn8),  ~mq8 & 32'hFF);
    chk("sout_l8", 32'(ol8),  32'(ml8));
    chk("sout_r8", 32'(or8),  32'(mr8));
    chk("q2",      32'(q2),   mq2);
    chk("q2_N",    32'(qn2),  ~mq2 & 32'h3);
    chk("sout_l2", 32'(ol2),  32'(ml2));
    chk("sout_r2", 32'(or2),  32'(mr2));
    chk("q16",     32'(q16),  mq16);
    chk("q16_N",   32'(qn16), ~mq16 & 32'hFFFF);
    chk("sout_l16", 32'(ol16), 32'(ml16));
    chk("sout_r16", 32'(or16), 32'(mr16));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    m8 = 3'd0; m2 = 3'd0; m16 = 3'd0;
    d8 = '0; d2 = '0; d16 = '0;
    sl8 = 0; sr8 = 0; sl2 = 0; sr2 = 0; sl16 = 0; sr16 = 0;
    step(2);
    chk("reset q8", 32'(q8), 32'hA5);
    rst_n = 1'b1;

    // Reset asserted mid-cycle acts before any edge
    m8 = 3'd1; d8 = 8'h11; step(1);
    chk("pre-reset load", 32'(q8), 32'h11);
    #1 rst_n = 1'b0;
    #1;
    chk("async q8",   32'(q8),  32'hA5);
    chk("async q8_N", 32'(qn8), 32'h5A);
    step(1);
    chk("reset ignores clock", 32'(q8), 32'hA5);
    rst_n = 1'b1; m8 = 3'd0; step(3);
    chk("hold after reset", 32'(q8), 32'hA5);

    m8 = 3'd1; d8 = 8'h3C; step(1);
    chk("load q",   32'(q8),  32'h3C);
    chk("load q_N", 32'(qn8), 32'hC3);
    m8 = 3'd0; d8 = 8'hFF; step(4);
    chk("hold ignores d", 32'(q8), 32'h3C);

    m8 = 3'd1; d8 = 8'h81; step(1);
    m8 = 3'd2; sl8 = 1'b0; step(1);
    chk("shl q", 32'(q8), 32'h02);
    chk("shl sout_l", 32'(ol8), 32'h1);
    m8 = 3'd3; sr8 = 1'b1; step(1);
    chk("shr q", 32'(q8), 32'h81);
    chk("shr sout_r", 32'(or8), 32'h0);
    m8 = 3'd2; sl8 = 1'b1; step(8);
    chk("shl fill", 32'(q8), 32'hFF);

    m8 = 3'd1; d8 = 8'h81; step(1);
    m8 = 3'd4; sl8 = 1'b0; step(1);
    chk("rol q", 32'(q8), 32'h03);
    chk("rol sout_l", 32'(ol8), 32'h1);
    m8 = 3'd5; step(1);
    chk("ror q", 32'(q8), 32'h81);
    chk("ror sout_r", 32'(or8), 32'h1);
    m8 = 3'd4;
    for (int i = 0; i < 8; i++) begin
      sl8 = ~sl8; sr8 = ~sr8; step(1);
    end
    chk("rol full turn", 32'(q8), 32'h81);

    m8 = 3'd1; d8 = 8'h5A; step(1);
    m8 = 3'd7; step(1);
    chk("set", 32'(q8), 32'hFF);
    m8 = 3'd6; step(1);
    chk("clr", 32'(q8), 32'h00);
    m8 = 3'd1; d8 = 8'h77;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset beats load", 32'(q8), 32'hA5);
    m8 = 3'd0; #1 rst_n = 1'b1;
    step(1);

    m2 = 3'd1; d2 = 2'b10; step(1);
    m2 = 3'd4; step(1);
    chk("w2 rol", 32'(q2), 32'h1);
    chk("w2 rol sout_l", 32'(ol2), 32'h1);
    m2 = 3'd2; sl2 = 1'b1; step(1);
    chk("w2 shl", 32'(q2), 32'h3);
    chk("w2 shl sout_l", 32'(ol2), 32'h0);
    m2 = 3'd3; sr2 = 1'b0; step(1);
    chk("w2 shr", 32'(q2), 32'h1);
    m2 = 3'd5; step(1);
    chk("w2 ror", 32'(q2), 32'h2);
    chk("w2 ror sout_r", 32'(or2), 32'h1);
    m2 = 3'd0;

    m16 = 3'd1; d16 = 16'h8000; step(1);
    m16 = 3'd2; sl16 = 1'b1; step(1);
    chk("w16 shl", 32'(q16), 32'h0001);
    chk("w16 shl sout_l", 32'(ol16), 32'h1);
    m16 = 3'd5; step(1);
    chk("w16 ror", 32'(q16), 32'h8000);
    chk("w16 ror sout_r", 32'(or16), 32'h1);
    m16 = 3'd3; sr16 = 1'b0; step(1);
    chk("w16 shr", 32'(q16), 32'h4000);
    chk("w16 shr sout_r", 32'(or16), 32'h0);
    m16 = 3'd4; step(8);
    chk("w16 rol8", 32'(q16), 32'h0040);
    m16 = 3'd0; step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
